// File: rtl/rv32i_fetch_stage.sv
// rv32i_fetch_stage: instruction fetch for the 5-stage RV32I pipeline.
// Holds the fetch PC and drives a synchronous instruction memory. Each
// returned word is paired with its PC on registered outputs for decode.
// Redirects from decode squash the in-flight word. Stalls freeze all state.
// EBREAK, or a misaligned redirect target, freezes fetch until reset.
module rv32i_fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP      = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall_in,
  input  logic        jump_en_in,
  input  logic [31:0] jump_addr_in,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  output logic [31:0] iw_out,
  output logic [31:0] pc_out,
  output logic        jump_en_out,
  output logic        halted_out,
  output logic        misalign_out
);

  localparam logic [31:0] EBREAK = 32'h0010_0073;

  typedef enum logic {FETCH, HALTED} state_t;

  state_t      state, state_next;
  logic [31:0] fetch_pc, fetch_pc_next;
  logic [31:0] pc_q, pc_q_next;
  logic        valid_q, valid_q_next;
  logic [31:0] iw_next;
  logic [31:0] pc_out_next;
  logic        jump_en_next;
  logic        misalign_next;
  logic        is_ebreak;

  // A stalled fetch re-presents the previous address so that the memory
  // word for pc_q is still on imem_rdata when the stall releases.
  assign imem_addr  = (stall_in && (state == FETCH)) ? pc_q : fetch_pc;
  assign halted_out = (state == HALTED);
  assign is_ebreak  = valid_q && (imem_rdata == EBREAK);

  // State and output registers; synchronous reset discards any pending redirect.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= FETCH;
      fetch_pc     <= RESET_PC;
      pc_q         <= 32'h0;
      valid_q      <= 1'b0;
      iw_out       <= NOP;
      pc_out       <= 32'h0;
      jump_en_out  <= 1'b0;
      misalign_out <= 1'b0;
    end else begin
      state        <= state_next;
      fetch_pc     <= fetch_pc_next;
      pc_q         <= pc_q_next;
      valid_q      <= valid_q_next;
      iw_out       <= iw_next;
      pc_out       <= pc_out_next;
      jump_en_out  <= jump_en_next;
      misalign_out <= misalign_next;
    end
  end

  // Next-state logic. Priority in FETCH is redirect, then stall, then EBREAK, then normal.
  always_comb begin
    state_next    = state;
    fetch_pc_next = fetch_pc;
    pc_q_next     = pc_q;
    valid_q_next  = valid_q;
    iw_next       = iw_out;
    pc_out_next   = pc_out;
    jump_en_next  = jump_en_out;
    misalign_next = misalign_out;

    case (state)
      FETCH: begin
        if (jump_en_in) begin
          valid_q_next = 1'b0;
          iw_next      = NOP;
          if (jump_addr_in[1:0] != 2'b00) begin
            // Unfetchable target: record it and freeze.
            misalign_next = 1'b1;
            jump_en_next  = 1'b0;
            state_next    = HALTED;
          end else begin
            fetch_pc_next = jump_addr_in;
            pc_out_next   = pc_q;
            jump_en_next  = 1'b1;
          end
        end else if (stall_in) begin
          // Hold everything.
        end else if (is_ebreak) begin
          // Hand the EBREAK to decode, then stop fetching.
          iw_next      = imem_rdata;
          pc_out_next  = pc_q;
          jump_en_next = 1'b0;
          valid_q_next = 1'b0;
          state_next   = HALTED;
        end else begin
          pc_q_next     = fetch_pc;
          valid_q_next  = 1'b1;
          fetch_pc_next = fetch_pc + 32'd4;
          iw_next       = valid_q ? imem_rdata : NOP;
          pc_out_next   = pc_q;
          jump_en_next  = 1'b0;
        end
      end
      HALTED: begin
        // Only reset leaves this state. Redirects and stalls are ignored.
        iw_next      = NOP;
        jump_en_next = 1'b0;
      end
      default: state_next = FETCH;
    endcase
  end

endmodule

// File: tb/tb_rv32i_fetch_stage.sv
// Testbench for rv32i_fetch_stage. The stimulus process advances a stream-level
// reference model and queues the expected outputs. A monitor pops and compares
// them after every rising edge.
module tb_rv32i_fetch_stage;

  localparam logic [31:0] RST_PC = 32'hFFFF_FFF8;
  localparam logic [31:0] NOPW   = 32'h0000_0013;
  localparam logic [31:0] EBRK   = 32'h0010_0073;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        stall_in = 1'b0;
  logic        jump_en_in = 1'b0;
  logic [31:0] jump_addr_in = 32'h0;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata = 32'h0;
  logic [31:0] iw_out, pc_out;
  logic        jump_en_out, halted_out, misalign_out;

  int checks = 0;
  int failures = 0;
  int txn = 0;

  rv32i_fetch_stage #(.RESET_PC(RST_PC), .NOP(NOPW)) dut (
    .clk(clk), .reset(reset), .stall_in(stall_in), .jump_en_in(jump_en_in),
    .jump_addr_in(jump_addr_in), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .iw_out(iw_out), .pc_out(pc_out), .jump_en_out(jump_en_out),
    .halted_out(halted_out), .misalign_out(misalign_out)
  );

  always #5 clk = ~clk;

  // Memory image: word at byte address a is a+0x100, except one EBREAK slot.
  logic [31:0] ebreak_addr = 32'hFFFF_FF00;
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a == ebreak_addr) ? EBRK : a + 32'h100;
  endfunction

  // Synchronous memory with a 1-cycle read latency.
  always @(posedge clk) imem_rdata <= mem_word(imem_addr);

  typedef struct {
    logic [31:0] iw, pc, addr;
    logic jen, halt, mis, chk_addr;
  } exp_t;
  exp_t sb[$];

  // The reference model tracks the issued instruction stream, not pipeline
  // registers: the next address to issue, the bubbles still owed before it,
  // and the PC reported with those bubbles.
  logic [31:0] m_next, m_bub_pc, m_iw, m_pc_out;
  int          m_bub;
  logic        m_halt, m_mis, m_jen;

  task automatic model_reset();
    m_next = RST_PC; m_bub = 1; m_bub_pc = 32'h0;
    m_iw = NOPW; m_pc_out = 32'h0; m_jen = 1'b0; m_halt = 1'b0; m_mis = 1'b0;
  endtask

  // Run one clock cycle with the given inputs and queue the expected outcome.
  task automatic cycle(input logic r, input logic s, input logic j, input logic [31:0] ja);
    exp_t e;
    logic [31:0] w;
    @(negedge clk);
    reset = r; stall_in = s; jump_en_in = j; jump_addr_in = ja;
    // Address this cycle: the in-flight address while stalled, otherwise the next to fetch.
    e.chk_addr = !r && !m_halt;
    if (s) e.addr = (m_bub > 0) ? m_bub_pc : m_next;
    else   e.addr = (m_bub > 0) ? m_next : m_next + 32'd4;
    if (r) begin
      model_reset();
    end else if (m_halt) begin
      m_iw = NOPW; m_jen = 1'b0;
    end else if (j) begin
      m_iw = NOPW;
      if (ja[1:0] != 2'b00) begin
        m_mis = 1'b1; m_halt = 1'b1; m_jen = 1'b0;
      end else begin
        m_pc_out = (m_bub > 0) ? m_bub_pc : m_next;
        m_bub_pc = m_pc_out;
        m_bub = 1; m_next = ja; m_jen = 1'b1;
      end
    end else if (s) begin
      // everything holds
    end else begin
      m_jen = 1'b0;
      if (m_bub > 0) begin
        m_iw = NOPW; m_pc_out = m_bub_pc; m_bub--;
      end else begin
        w = mem_word(m_next);
        m_iw = w; m_pc_out = m_next;
        if (w == EBRK) m_halt = 1'b1;
        else m_next = m_next + 32'd4;
      end
    end
    e.iw = m_iw; e.pc = m_pc_out; e.jen = m_jen; e.halt = m_halt; e.mis = m_mis;
    sb.push_back(e);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s txn=%0d actual=%h required=%h", name, txn, act, exp);
    end
  endtask

  // Capture the combinational address mid-cycle, after inputs settle.
  logic [31:0] addr_seen;
  initial forever begin
    @(negedge clk); #1;
    addr_seen = imem_addr;
  end

  // Monitor: compare every registered output after each rising edge.
  initial forever begin
    exp_t e;
    @(posedge clk); #1;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      txn++;
      check("iw_out", iw_out, e.iw);
      check("pc_out", pc_out, e.pc);
      check("jump_en_out", {31'b0, jump_en_out}, {31'b0, e.jen});
      check("halted_out", {31'b0, halted_out}, {31'b0, e.halt});
      check("misalign_out", {31'b0, misalign_out}, {31'b0, e.mis});
      if (e.chk_addr) check("imem_addr", addr_seen, e.addr);
      $display("txn %0d iw=%h pc=%h jen=%b halt=%b mis=%b addr=%h",
               txn, iw_out, pc_out, jump_en_out, halted_out, misalign_out, addr_seen);
    end
  end

  initial begin
    bit jumped;
    model_reset();
    // Reset, then straight-line fetch across the 32-bit wrap.
    cycle(1, 0, 0, 0); cycle(1, 0, 0, 0);
    repeat (12) cycle(0, 0, 0, 0);
    // A redirect mid-stream, and another on the following cycle.
    cycle(0, 0, 1, 32'h40);
    repeat (4) cycle(0, 0, 0, 0);
    cycle(0, 0, 1, 32'h80); cycle(0, 0, 1, 32'hA0);
    repeat (4) cycle(0, 0, 0, 0);
    // Three-cycle stall mid-stream, then a redirect taken during a stall.
    repeat (3) cycle(0, 1, 0, 0);
    repeat (3) cycle(0, 0, 0, 0);
    cycle(0, 1, 1, 32'h200); cycle(0, 1, 0, 0);
    repeat (4) cycle(0, 0, 0, 0);
    // EBREAK at 0x0C: it issues, then fetch halts and ignores redirects.
    ebreak_addr = 32'h0C;
    cycle(1, 0, 0, 0);
    repeat (10) cycle(0, 0, 0, 0);
    cycle(0, 0, 1, 32'h40); cycle(0, 1, 0, 0);
    repeat (2) cycle(0, 0, 0, 0);
    // Reset taken during a stall and a redirect restarts from RESET_PC.
    cycle(1, 1, 1, 32'h300);
    repeat (4) cycle(0, 0, 0, 0);
    // Misaligned redirect target.
    cycle(0, 0, 1, 32'h42);
    cycle(0, 0, 1, 32'h80); cycle(0, 1, 0, 0);
    repeat (2) cycle(0, 0, 0, 0);
    // EBREAK in flight while a redirect is accepted: the redirect wins.
    ebreak_addr = 32'h08;
    cycle(1, 0, 0, 0);
    jumped = 0;
    for (int i = 0; i < 14; i++) begin
      if (!jumped && m_bub == 0 && m_next == 32'h08) begin
        cycle(0, 0, 1, 32'h60); jumped = 1;
      end else begin
        cycle(0, 0, 0, 0);
      end
    end
    // Randomized stalls, redirects, misaligned targets and resets.
    ebreak_addr = 32'h30;
    cycle(1, 0, 0, 0);
    for (int i = 0; i < 600; i++) begin
      logic r, s, j;
      logic [31:0] ja;
      r = ($urandom_range(0, 59) == 0);
      s = ($urandom_range(0, 3) == 0);
      j = ($urandom_range(0, 9) == 0);
      ja = {24'h0, 6'($urandom_range(0, 63)), 2'b00};
      if ($urandom_range(0, 11) == 0) ja[1:0] = 2'($urandom_range(1, 3));
      cycle(r, s, j, ja);
    end
    cycle(0, 0, 0, 0);
    // Drain the scoreboard with a bounded wait.
    repeat (3) @(posedge clk);
    #2;
    check("scoreboard_drained", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
